// File: rtl/cpu_pkg.sv
// Constants and types shared by the output-port decode, the control unit and
// the buffered output-port stage.
package cpu_pkg;

  localparam int NPORTS = 4;
  localparam int WORD_W = 8;

  typedef logic [1:0]        port_idx_t;
  typedef logic [WORD_W-1:0] port_word_t;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/out_port_buffer_if.sv
// Port-write tap from the CPU plus the per-port valid/ready device side.
// The buffer is the slave; the CPU/device side is the master.
interface out_port_buffer_if
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W
);

  logic                we;
  port_idx_t           sel_port;
  logic [WIDTH-1:0]    in_RD2;
  logic [WIDTH-1:0]    port_data [NPORTS];
  logic [NPORTS-1:0]   port_valid;
  logic [NPORTS-1:0]   port_ready;
  logic [NPORTS-1:0]   port_full;
  logic                stall;
  logic [NPORTS-1:0]   overflow;
  logic                ovf_clr;

  modport master (
    output we, sel_port, in_RD2, port_ready, ovf_clr,
    input  port_data, port_valid, port_full, stall, overflow
  );

  modport slave (
    input  we, sel_port, in_RD2, port_ready, ovf_clr,
    output port_data, port_valid, port_full, stall, overflow
  );

endinterface

// File: rtl/deco.sv
// Binary-to-one-hot decoder with enable, used for port write steering.
module deco #(
  parameter int N = 2
) (
  input  logic             en,
  input  logic [N-1:0]     sel,
  output logic [2**N-1:0]  y
);

  always_comb begin
    // NOTE: default assigned first so every path drives y and no latch is inferred.
    y = '0;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/port_fifo.sv
// Single synchronous FIFO; DEPTH must be a power of two (>= 2) so the
// log2(DEPTH)-bit pointers wrap naturally.
module port_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a write when its head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      // NOTE: storage is reset so port_data is a known 0 rather than X after reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update on the old values.
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/out_port_buffer.sv
// Buffered output-port stage: captures each port write into a per-port FIFO
// and presents it to the device through valid/ready, with stall/overflow.
module out_port_buffer
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 2
) (
  input logic              clk,
  input logic              rst_n,
  out_port_buffer_if.slave bus
);

  localparam int CW = count_width(DEPTH);

  logic [NPORTS-1:0] wr_en;
  logic [NPORTS-1:0] pop;
  logic [NPORTS-1:0] full;
  logic [NPORTS-1:0] empty;
  logic [NPORTS-1:0] drop;
  logic [NPORTS-1:0] overflow_q;
  logic [CW-1:0]     cnt   [NPORTS];
  logic [WIDTH-1:0]  rdata [NPORTS];

  deco #(.N(2)) u_deco (
    .en  (bus.we),
    .sel (bus.sel_port),
    .y   (wr_en)
  );

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    assign pop[i] = bus.port_ready[i] & ~empty[i];

    port_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (wr_en[i]),
      .pop   (pop[i]),
      .wdata (bus.in_RD2),
      .rdata (rdata[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .count (cnt[i])
    );

    assign bus.port_data[i] = rdata[i];
    // Only a write to a full port whose head is not leaving this cycle is lost.
    assign drop[i] = wr_en[i] & full[i] & ~pop[i];
  end

  assign bus.port_valid = ~empty;
  assign bus.port_full  = full;
  assign bus.stall      = bus.we & (cnt[bus.sel_port] == CW'(DEPTH));
  assign bus.overflow   = overflow_q;

  // A drop in the same cycle as ovf_clr keeps its bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= '0;
    else        overflow_q <= drop | (bus.ovf_clr ? '0 : overflow_q);
  end

endmodule

// File: doc/out_port_buffer.md
# out_port_buffer

Buffered output-port stage sitting directly downstream of the CPU's output-port decode. It taps the same port-write strobe, port select and register-file read data (RD2) that drive the output ports. It captures every port write into a small per-port FIFO and presents each port to its external device through a valid/ready handshake, so a device no longer has to sample the single-cycle, zero-when-idle port value. Per-port full and overflow flags go back to the control unit for stalling or diagnostics.

## Interface
Parameters:
- `WIDTH`, 8: port data width.
- `DEPTH`, 2: entries per port FIFO. Must be a power of two and at least 2.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `we`  in  1  port-write strobe from the control unit (same net that enables the output ports).
- `sel_port`  in  2  target port index, 0..3.
- `in_RD2`  in  WIDTH  write data (register-file read port 2).
- `port_data[0..3]`  out  WIDTH each  head-of-FIFO data per port.
- `port_valid[0..3]`  out  1 each  head entry is valid.
- `port_ready[0..3]`  in  1 each  device accepts the head entry.
- `port_full`  out  4  per-port FIFO full.
- `stall`  out  1  combinational: `we & port_full[sel_port]`.
- `overflow`  out  4  sticky per-port flag: a write was dropped.
- `ovf_clr`  in  1  synchronous clear of all overflow bits.

## Operation
- Push: `we` is high and the FIFO at `sel_port` is not full (or is popped in the same cycle). `in_RD2` is written at the tail and the count is incremented.
- Pop: `port_valid[i] & port_ready[i]`. The head advances and the count is decremented.
- Simultaneous push and pop on the same port:
  - Both happen and the count is unchanged.
  - This holds when the FIFO is full; that write is accepted, not dropped.
- Simultaneous push and pop on the same port when the FIFO is empty:
  - The pop is impossible because valid is 0.
  - The push proceeds.
- Write to a full port with no pop that cycle:
  - The data is discarded.
  - `overflow[sel_port]` is set on the next edge.
  - FIFO contents are unchanged.
- `ovf_clr` and a new overflow in the same cycle: set wins.
- Ports are fully independent. A push to one port and pops on any other ports can all occur in one cycle.
- Data value 0 is a legal payload. Validity comes only from the count, never from the data value.
- Pointers: log2(DEPTH)-bit read/write pointers that wrap modulo DEPTH. The count is log2(DEPTH)+1 bits, range 0..DEPTH.
- `port_data[i]` is storage[rd_ptr]. Its value is don't-care when valid is 0, but it is driven from registers, never X after reset.

## Timing
- Reset (async assert, sync deassert expected upstream):
  - all counts and pointers 0
  - `port_valid` = 0
  - `port_full` = 0
  - `overflow` = 0
  - storage = 0, so `port_data` = 0
  - `stall` = 0
- Reset asserted mid-transfer flushes all FIFOs immediately. Lost entries are not reported.
- Write latency: a push at edge N gives `port_valid` high and `port_data` equal to the written value after edge N; it is visible in cycle N+1.
- A pop at edge N shows the next entry, or valid=0, after edge N.
- `port_full` and `port_valid` are registered-state decodes: no combinational path from `port_ready` or `we`.
- `stall` is the only combinational output.
- The device may hold `port_ready` high continuously; the block then sustains one transfer per cycle per port.
- Valid, once high, stays high and its data stays stable until it is accepted (AXI-style rule).

## Structure
- Shared package `cpu_pkg`:
  - `NPORTS` = 4
  - `port_idx_t` (2-bit)
  - `port_word_t` (WIDTH-bit)
- This constant set is shared with the output-port decode and the control unit.
- Sub-module `port_fifo`: a single synchronous FIFO with push/pop/full/empty/count.
- `out_port_buffer` instantiates four `port_fifo` instances with a generate loop.
- Write steering is done with the existing `deco` decoder on `sel_port`, gated by `we`.
- The overflow and stall logic is at the top level.

## Test plan
- Reset then idle: all outputs are 0. Write 0x00 to port 2 → `port_valid[2]`=1, `port_data[2]`=0x00 next cycle; other ports stay invalid.
- Ready low on port 1, write 0x11 then 0x22 → `port_full[1]`=1. A third write of 0x33 → `stall`=1 during that cycle, `overflow[1]`=1, and draining yields 0x11, 0x22 only.
- Port 0 full. In the same cycle `port_ready[0]`=1 and write 0x44 → head 0x11 accepted, count stays 2, a later drain yields 0x22, 0x44, and `overflow[0]` stays 0.
- `port_ready[3]` held high, back-to-back writes 0x01..0x08 to port 3 → the device sees 8 transfers in order, one per cycle, with `port_full[3]` never set.
- Writes in flight to all ports, assert `rst_n`=0 for 1 cycle mid-stream → all valid and full drop immediately; after release, a write of 0xA5 to port 0 appears normally.
- Set `overflow[2]`, then assert `ovf_clr` in the same cycle as a new dropped write to port 2 → `overflow[2]` remains 1. A subsequent `ovf_clr` alone → 0.
